redmule_tile_sequencer: RTL and testbench

Consumes the tiling parameters that the RedMulE tiler computes and walks the three-level tile loop. Loop order: M rows, then K columns, then N reduction. For each tile it emits one descriptor carrying tile indices, X/W/Z base addresses and boundary flags. Descriptors leave on a valid/ready stream to the streamer/scheduler stage. The block sits between the tiler output and the data-movement control, and replaces ad-hoc per-streamer counters with a single authoritative iteration source.

---
 rtl/redmule_tile_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_redmule_tile_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tile_sequencer.sv
// Walks the RedMulE M/K/N tile loop and emits one registered descriptor per tile on a valid/ready stream.
// Optional stall counter output enabled by defining REDMULE_TILE_SEQ_STALL_CNT_EN.
module redmule_tile_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ITER_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ITER_W-1:0] x_rows_iter_i,
  input  logic [ITER_W-1:0] w_cols_iter_i,
  input  logic [ITER_W-1:0] x_cols_iter_i,
  input  logic [7:0]        x_rows_lftovr_i,
  input  logic [7:0]        w_cols_lftovr_i,
  input  logic [7:0]        x_cols_lftovr_i,
  input  logic [ADDR_W-1:0] x_base_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] z_base_i,
  input  logic [ADDR_W-1:0] x_rows_offs_i,
  input  logic [ADDR_W-1:0] x_col_step_i,
  input  logic [ADDR_W-1:0] w_row_step_i,
  input  logic [ADDR_W-1:0] w_col_step_i,
  input  logic [ADDR_W-1:0] z_d2_stride_i,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [ITER_W-1:0] m_idx_o,
  output logic [ITER_W-1:0] k_idx_o,
  output logic [ITER_W-1:0] n_idx_o,
  output logic [ADDR_W-1:0] x_addr_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [ADDR_W-1:0] z_addr_o,
  output logic              first_n_o,
  output logic              last_n_o,
  output logic              m_lftovr_o,
  output logic              k_lftovr_o,
  output logic              n_lftovr_o,
  output logic              last_o,
  output logic              busy_o,
`ifdef REDMULE_TILE_SEQ_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
`endif
  output logic              done_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_reg;
  logic [ITER_W-1:0] m_iter_reg, k_iter_reg, n_iter_reg;
  logic              m_lo_reg, k_lo_reg, n_lo_reg;
  logic [ADDR_W-1:0] x_rows_offs_reg, x_col_step_reg, w_row_step_reg;
  logic [ADDR_W-1:0] w_col_step_reg, z_d2_stride_reg, w_base_reg;
  // Row/column base accumulators that the inner-loop addresses reload from on wrap
  logic [ADDR_W-1:0] x_m_acc_reg, w_k_acc_reg, z_m_acc_reg;

  logic              start_ok, iters_nz, hs, advance, n_wrap, k_wrap;
  logic [ITER_W-1:0] m_cnt, k_cnt, n_cnt;
  logic              m_lo, k_lo, n_lo;
  logic [ITER_W-1:0] m_next, k_next, n_next;
  logic [ADDR_W-1:0] x_addr_next, w_addr_next, z_addr_next;
  logic [ADDR_W-1:0] x_m_acc_next, w_k_acc_next, z_m_acc_next;
  logic              m_last_next, k_last_next, n_last_next;

  assign start_ok = (state_reg == IDLE) && start_i;
  assign iters_nz = (|x_rows_iter_i) && (|w_cols_iter_i) && (|x_cols_iter_i);
  assign hs       = desc_valid_o && desc_ready_i;
  assign advance  = hs && !last_o;
  assign n_wrap   = (n_idx_o == n_iter_reg - ITER_W'(1));
  assign k_wrap   = (k_idx_o == k_iter_reg - ITER_W'(1));

  // Flags are derived from the next indices, so take the counts from the inputs on start
  assign m_cnt = start_ok ? x_rows_iter_i : m_iter_reg;
  assign k_cnt = start_ok ? w_cols_iter_i : k_iter_reg;
  assign n_cnt = start_ok ? x_cols_iter_i : n_iter_reg;
  assign m_lo  = start_ok ? (|x_rows_lftovr_i) : m_lo_reg;
  assign k_lo  = start_ok ? (|w_cols_lftovr_i) : k_lo_reg;
  assign n_lo  = start_ok ? (|x_cols_lftovr_i) : n_lo_reg;

  always_comb begin
    m_next       = m_idx_o;
    k_next       = k_idx_o;
    n_next       = n_idx_o;
    x_addr_next  = x_addr_o;
    w_addr_next  = w_addr_o;
    z_addr_next  = z_addr_o;
    x_m_acc_next = x_m_acc_reg;
    w_k_acc_next = w_k_acc_reg;
    z_m_acc_next = z_m_acc_reg;
    if (start_ok) begin
      m_next       = '0;
      k_next       = '0;
      n_next       = '0;
      x_addr_next  = x_base_i;
      w_addr_next  = w_base_i;
      z_addr_next  = z_base_i;
      x_m_acc_next = x_base_i;
      w_k_acc_next = w_base_i;
      z_m_acc_next = z_base_i;
    end else if (advance) begin
      if (!n_wrap) begin
        n_next      = n_idx_o + ITER_W'(1);
        x_addr_next = x_addr_o + x_col_step_reg;
        w_addr_next = w_addr_o + w_row_step_reg;
      end else if (!k_wrap) begin
        n_next       = '0;
        k_next       = k_idx_o + ITER_W'(1);
        x_addr_next  = x_m_acc_reg;
        w_k_acc_next = w_k_acc_reg + w_col_step_reg;
        w_addr_next  = w_k_acc_reg + w_col_step_reg;
        z_addr_next  = z_addr_o + w_col_step_reg;
      end else begin
        n_next       = '0;
        k_next       = '0;
        m_next       = m_idx_o + ITER_W'(1);
        x_m_acc_next = x_m_acc_reg + x_rows_offs_reg;
        x_addr_next  = x_m_acc_reg + x_rows_offs_reg;
        w_k_acc_next = w_base_reg;
        w_addr_next  = w_base_reg;
        z_m_acc_next = z_m_acc_reg + z_d2_stride_reg;
        z_addr_next  = z_m_acc_reg + z_d2_stride_reg;
      end
    end
  end

  assign m_last_next = (m_next == m_cnt - ITER_W'(1));
  assign k_last_next = (k_next == k_cnt - ITER_W'(1));
  assign n_last_next = (n_next == n_cnt - ITER_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      state_reg       <= IDLE;
      m_iter_reg      <= '0;
      k_iter_reg      <= '0;
      n_iter_reg      <= '0;
      m_lo_reg        <= 1'b0;
      k_lo_reg        <= 1'b0;
      n_lo_reg        <= 1'b0;
      x_rows_offs_reg <= '0;
      x_col_step_reg  <= '0;
      w_row_step_reg  <= '0;
      w_col_step_reg  <= '0;
      z_d2_stride_reg <= '0;
      w_base_reg      <= '0;
      x_m_acc_reg     <= '0;
      w_k_acc_reg     <= '0;
      z_m_acc_reg     <= '0;
      m_idx_o         <= '0;
      k_idx_o         <= '0;
      n_idx_o         <= '0;
      x_addr_o        <= '0;
      w_addr_o        <= '0;
      z_addr_o        <= '0;
      first_n_o       <= 1'b0;
      last_n_o        <= 1'b0;
      m_lftovr_o      <= 1'b0;
      k_lftovr_o      <= 1'b0;
      n_lftovr_o      <= 1'b0;
      last_o          <= 1'b0;
      desc_valid_o    <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      if (start_ok) begin
        m_iter_reg      <= x_rows_iter_i;
        k_iter_reg      <= w_cols_iter_i;
        n_iter_reg      <= x_cols_iter_i;
        m_lo_reg        <= |x_rows_lftovr_i;
        k_lo_reg        <= |w_cols_lftovr_i;
        n_lo_reg        <= |x_cols_lftovr_i;
        x_rows_offs_reg <= x_rows_offs_i;
        x_col_step_reg  <= x_col_step_i;
        w_row_step_reg  <= w_row_step_i;
        w_col_step_reg  <= w_col_step_i;
        z_d2_stride_reg <= z_d2_stride_i;
        w_base_reg      <= w_base_i;
      end
      if ((start_ok && iters_nz) || advance) begin
        m_idx_o     <= m_next;
        k_idx_o     <= k_next;
        n_idx_o     <= n_next;
        x_addr_o    <= x_addr_next;
        w_addr_o    <= w_addr_next;
        z_addr_o    <= z_addr_next;
        x_m_acc_reg <= x_m_acc_next;
        w_k_acc_reg <= w_k_acc_next;
        z_m_acc_reg <= z_m_acc_next;
        first_n_o   <= (n_next == '0);
        last_n_o    <= n_last_next;
        m_lftovr_o  <= m_last_next && m_lo;
        k_lftovr_o  <= k_last_next && k_lo;
        n_lftovr_o  <= n_last_next && n_lo;
        last_o      <= m_last_next && k_last_next && n_last_next;
      end
      case (state_reg)
        IDLE: if (start_i) begin
          busy_o <= 1'b1;
          if (iters_nz) begin
            state_reg    <= RUN;
            desc_valid_o <= 1'b1;
          end else begin
            state_reg <= DONE;
            done_o    <= 1'b1;
          end
        end
        RUN: if (hs && last_o) begin
          state_reg    <= DONE;
          desc_valid_o <= 1'b0;
          done_o       <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          busy_o    <= 1'b0;
          done_o    <= 1'b0;
        end
      endcase
    end
  end

`ifdef REDMULE_TILE_SEQ_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      stall_cnt_o <= '0;
    end else if (start_ok) begin
      stall_cnt_o <= '0;
    end else if (desc_valid_o && !desc_ready_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
// Directed self-checking bench for redmule_tile_sequencer; outputs sampled on the falling edge.
module tb_redmule_tile_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_ni, clear_i, start_i, desc_ready_i;
  logic [15:0] x_rows_iter_i, w_cols_iter_i, x_cols_iter_i;
  logic [7:0]  x_rows_lftovr_i, w_cols_lftovr_i, x_cols_lftovr_i;
  logic [31:0] x_base_i, w_base_i, z_base_i, x_rows_offs_i, x_col_step_i;
  logic [31:0] w_row_step_i, w_col_step_i, z_d2_stride_i;
  logic        desc_valid_o, first_n_o, last_n_o, m_lftovr_o, k_lftovr_o, n_lftovr_o;
  logic        last_o, busy_o, done_o;
  logic [15:0] m_idx_o, k_idx_o, n_idx_o;
  logic [31:0] x_addr_o, w_addr_o, z_addr_o;
`ifdef REDMULE_TILE_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] x_exp1 [6] = '{32'h1000, 32'h1020, 32'h1040, 32'h1100, 32'h1120, 32'h1140};
  logic [31:0] w_exp2 [4] = '{32'h0, 32'h40, 32'h10, 32'h50};
  logic [31:0] z_exp2 [4] = '{32'h8000, 32'h8000, 32'h8010, 32'h8010};
  logic [63:0] snap;

  always #5 clk_i = ~clk_i;

  redmule_tile_sequencer #(.ADDR_W(32), .ITER_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .x_rows_iter_i(x_rows_iter_i), .w_cols_iter_i(w_cols_iter_i), .x_cols_iter_i(x_cols_iter_i),
    .x_rows_lftovr_i(x_rows_lftovr_i), .w_cols_lftovr_i(w_cols_lftovr_i),
    .x_cols_lftovr_i(x_cols_lftovr_i),
    .x_base_i(x_base_i), .w_base_i(w_base_i), .z_base_i(z_base_i),
    .x_rows_offs_i(x_rows_offs_i), .x_col_step_i(x_col_step_i), .w_row_step_i(w_row_step_i),
    .w_col_step_i(w_col_step_i), .z_d2_stride_i(z_d2_stride_i),
    .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
    .m_idx_o(m_idx_o), .k_idx_o(k_idx_o), .n_idx_o(n_idx_o),
    .x_addr_o(x_addr_o), .w_addr_o(w_addr_o), .z_addr_o(z_addr_o),
    .first_n_o(first_n_o), .last_n_o(last_n_o), .m_lftovr_o(m_lftovr_o),
    .k_lftovr_o(k_lftovr_o), .n_lftovr_o(n_lftovr_o), .last_o(last_o), .busy_o(busy_o),
`ifdef REDMULE_TILE_SEQ_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .done_o(done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int m, input int k, input int n);
    x_rows_iter_i = 16'(m);
    w_cols_iter_i = 16'(k);
    x_cols_iter_i = 16'(n);
    x_rows_lftovr_i = 8'd0; w_cols_lftovr_i = 8'd0; x_cols_lftovr_i = 8'd0;
    x_base_i = 32'd0; w_base_i = 32'd0; z_base_i = 32'd0;
    x_rows_offs_i = 32'd0; x_col_step_i = 32'd0; w_row_step_i = 32'd0;
    w_col_step_i = 32'd0; z_d2_stride_i = 32'd0;
  endtask

  // Called at a falling edge; returns at the falling edge of the cycle after start
  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; desc_ready_i = 1'b1;
    set_cfg(0, 0, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_valid", 32'(desc_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_xaddr", x_addr_o, 32'd0);
    check("rst_last", 32'(last_o), 32'd0);

    // Job 1: M=2 K=1 N=3, always ready; a stray start mid-job must be ignored
    set_cfg(2, 1, 3);
    x_base_i = 32'h1000; x_rows_offs_i = 32'h100; x_col_step_i = 32'h20;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      check("j1_valid", 32'(desc_valid_o), 32'd1);
      check("j1_xaddr", x_addr_o, x_exp1[i]);
      check("j1_n", 32'(n_idx_o), 32'(i % 3));
      check("j1_m", 32'(m_idx_o), 32'(i / 3));
      check("j1_last", 32'(last_o), 32'(i == 5));
      start_i = (i == 1);
      if (i == 1) x_base_i = 32'h9999;
      @(negedge clk_i);
      start_i = 1'b0;
    end
    check("j1_done", 32'(done_o), 32'd1);
    check("j1_valid_off", 32'(desc_valid_o), 32'd0);
    check("j1_busy_done", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    check("j1_done_pulse", 32'(done_o), 32'd0);
    check("j1_idle_busy", 32'(busy_o), 32'd0);

    // Job 2: M=1 K=2 N=2, W/Z address walk
    set_cfg(1, 2, 2);
    w_row_step_i = 32'h40; w_col_step_i = 32'h10; z_base_i = 32'h8000;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("j2_waddr", w_addr_o, w_exp2[i]);
      check("j2_zaddr", z_addr_o, z_exp2[i]);
      check("j2_k", 32'(k_idx_o), 32'(i / 2));
      check("j2_first_n", 32'(first_n_o), 32'((i % 2) == 0));
      check("j2_last_n", 32'(last_n_o), 32'((i % 2) == 1));
      @(negedge clk_i);
    end
    check("j2_done", 32'(done_o), 32'd1);
    @(negedge clk_i);

    // Job 3: 2x2x2 with ready toggling; fields must hold across each stall
    set_cfg(2, 2, 2);
    x_rows_offs_i = 32'h200; x_col_step_i = 32'h8;
    pulse_start();
    for (int d = 0; d < 8; d++) begin
      desc_ready_i = 1'b0;
      check("j3_valid_stall", 32'(desc_valid_o), 32'd1);
      snap = {m_idx_o, k_idx_o, x_addr_o};
      @(negedge clk_i);
      desc_ready_i = 1'b1;
      check("j3_valid_hs", 32'(desc_valid_o), 32'd1);
      check("j3_hold_idx", {m_idx_o, k_idx_o}, snap[63:32]);
      check("j3_hold_xaddr", x_addr_o, snap[31:0]);
      check("j3_n", 32'(n_idx_o), 32'(d % 2));
      check("j3_k", 32'(k_idx_o), 32'((d / 2) % 2));
      check("j3_xaddr", x_addr_o, 32'((d / 4) * 32'h200 + (d % 2) * 8));
      @(negedge clk_i);
    end
    check("j3_done", 32'(done_o), 32'd1);
`ifdef REDMULE_TILE_SEQ_STALL_CNT_EN
    check("j3_stall_cnt", stall_cnt_o, 32'd8);
    @(negedge clk_i);
    check("j3_stall_hold", stall_cnt_o, 32'd8);
`else
    @(negedge clk_i);
`endif

    // Job 4: zero N iterations -> no descriptor, immediate done
    set_cfg(3, 3, 0);
    pulse_start();
    check("j4_valid", 32'(desc_valid_o), 32'd0);
    check("j4_done", 32'(done_o), 32'd1);
    check("j4_busy", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    check("j4_done_off", 32'(done_o), 32'd0);
    check("j4_busy_off", 32'(busy_o), 32'd0);

    // Job 5: 2x2x1 with M leftover only
    set_cfg(2, 2, 1);
    x_rows_lftovr_i = 8'd5;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("j5_m_lftovr", 32'(m_lftovr_o), 32'(i >= 2));
      check("j5_k_lftovr", 32'(k_lftovr_o), 32'd0);
      check("j5_n_lftovr", 32'(n_lftovr_o), 32'd0);
      check("j5_last_n", 32'(last_n_o), 32'd1);
      @(negedge clk_i);
    end
    check("j5_done", 32'(done_o), 32'd1);
    @(negedge clk_i);

    // Job 6: clear after third handshake, then restart
    set_cfg(2, 2, 2);
    x_base_i = 32'h40;
    pulse_start();
    repeat (3) @(negedge clk_i);
    check("j6_pre_k", 32'(k_idx_o), 32'd1);
    check("j6_pre_n", 32'(n_idx_o), 32'd1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    check("j6_clr_valid", 32'(desc_valid_o), 32'd0);
    check("j6_clr_busy", 32'(busy_o), 32'd0);
    check("j6_clr_done", 32'(done_o), 32'd0);
    check("j6_clr_k", 32'(k_idx_o), 32'd0);
    @(negedge clk_i);
    check("j6_no_done", 32'(done_o), 32'd0);
    pulse_start();
    check("j6_rs_valid", 32'(desc_valid_o), 32'd1);
    check("j6_rs_mkn", {16'(m_idx_o), 8'(k_idx_o), 8'(n_idx_o)}, 32'd0);
    check("j6_rs_xaddr", x_addr_o, 32'h40);
    check("j6_rs_first", 32'(first_n_o), 32'd1);
    repeat (8) @(negedge clk_i);
    check("j6_done", 32'(done_o), 32'd1);
    @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
